// File: rtl/rc_arbiter_if.sv
// Route-computation arbiter bus: port encoding plus the shared handshake bundle.
// Requesters drive req/dest/ready; the arbiter returns grant/port/err with valid.
package noc_params;
    typedef enum logic [2:0] {
        LOCAL,
        NORTH,
        SOUTH,
        WEST,
        EAST
    } port_t;
endpackage

interface rc_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int X_W   = 3,
    parameter int Y_W   = 3
);
    import noc_params::*;

    logic [N_REQ-1:0]          req_i;
    logic [N_REQ-1:0][X_W-1:0] x_dest_i;
    logic [N_REQ-1:0][Y_W-1:0] y_dest_i;
    logic                      ready_i;
    logic                      valid_o;
    logic [N_REQ-1:0]          grant_o;
    port_t                     out_port_o;
    logic                      err_o;

    modport master (
        output req_i, x_dest_i, y_dest_i, ready_i,
        input  valid_o, grant_o, out_port_o, err_o
    );

    modport slave (
        input  req_i, x_dest_i, y_dest_i, ready_i,
        output valid_o, grant_o, out_port_o, err_o
    );
endinterface

// File: rtl/rc_arbiter.sv
// Round-robin arbiter sharing one XY route computation among N_REQ VCs.
// Optional macro RC_ARBITER_DEST_CHECK_EN flags destinations outside the mesh.
module rc_arbiter
    import noc_params::*;
#(
    parameter int N_REQ       = 4,
    parameter int MESH_SIZE_X = 5,
    parameter int MESH_SIZE_Y = 7,
    parameter int X_CURRENT   = MESH_SIZE_X / 2,
    parameter int Y_CURRENT   = MESH_SIZE_Y / 2
) (
    input logic        clk,
    input logic        rst,
    rc_arbiter_if.slave bus
);
    localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
    localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        IDLE,
        VALID
    } state_t;

    state_t                      state, state_n;
    logic [PTR_W-1:0]            ptr, ptr_n;
    logic [N_REQ-1:0]            grant, grant_n;
    port_t                       port_q, port_n;
    logic                        err, err_n;
    logic [N_REQ-1:0]            cand;
    logic                        found;
    logic                        load;
    logic [PTR_W-1:0]            win;
    logic [DEST_ADDR_SIZE_X-1:0] xd;
    logic [DEST_ADDR_SIZE_Y-1:0] yd;

    function automatic port_t route(
        input logic [DEST_ADDR_SIZE_X-1:0] x,
        input logic [DEST_ADDR_SIZE_Y-1:0] y
    );
        if (x < DEST_ADDR_SIZE_X'(X_CURRENT))      return WEST;
        else if (x > DEST_ADDR_SIZE_X'(X_CURRENT)) return EAST;
        else if (y < DEST_ADDR_SIZE_Y'(Y_CURRENT)) return NORTH;
        else if (y > DEST_ADDR_SIZE_Y'(Y_CURRENT)) return SOUTH;
        else                                       return LOCAL;
    endfunction

    // Eligible set and round-robin pick starting just after the last winner
    always_comb begin
        cand  = '0;
        found = 1'b0;
        win   = '0;
        if (state == IDLE) begin
            cand = bus.req_i;
        end else if (bus.ready_i) begin
            cand = bus.req_i & ~grant;
        end
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && cand[(int'(ptr) + k) % N_REQ]) begin
                found = 1'b1;
                win   = PTR_W'((int'(ptr) + k) % N_REQ);
            end
        end
        xd = bus.x_dest_i[win];
        yd = bus.y_dest_i[win];
    end

    // Next-state, next result and pointer update
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        grant_n = grant;
        port_n  = port_q;
        err_n   = err;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    load    = 1'b1;
                    state_n = VALID;
                end
            end
            VALID: begin
                if (bus.ready_i) begin
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        err_n   = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            grant_n      = '0;
            grant_n[win] = 1'b1;
            ptr_n        = win;
`ifdef RC_ARBITER_DEST_CHECK_EN
            if (int'(xd) >= MESH_SIZE_X || int'(yd) >= MESH_SIZE_Y) begin
                port_n = LOCAL;
                err_n  = 1'b1;
            end else begin
                port_n = route(xd, yd);
                err_n  = 1'b0;
            end
`else
            port_n = route(xd, yd);
            err_n  = 1'b0;
`endif
        end
    end

    // State and result registers; ptr resets so index 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= PTR_W'(N_REQ - 1);
            grant  <= '0;
            port_q <= LOCAL;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            grant  <= grant_n;
            port_q <= port_n;
            err    <= err_n;
        end
    end

    assign bus.valid_o    = (state == VALID);
    assign bus.grant_o    = grant;
    assign bus.out_port_o = port_q;
    assign bus.err_o      = err;
endmodule

// File: tb/tb_rc_arbiter.sv
// Scoreboard bench for rc_arbiter: stimulus queues expected results,
// a negedge monitor pops one per completed handshake and compares.
module tb_rc_arbiter;
    import noc_params::*;

    typedef struct packed {
        logic [3:0] grant;
        port_t      port;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    exp_t exp_q[$];

    rc_arbiter_if #(.N_REQ(4), .X_W(3), .Y_W(3)) bus ();

    rc_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Independent XY reference for router (2,3) in a 5x7 mesh
    function automatic exp_t mk(input int r, input int x, input int y);
        exp_t e;
        e.grant = 4'b0001 << r;
        e.err   = 1'b0;
        if (x < 2)      e.port = WEST;
        else if (x > 2) e.port = EAST;
        else if (y < 3) e.port = NORTH;
        else if (y > 3) e.port = SOUTH;
        else            e.port = LOCAL;
`ifdef RC_ARBITER_DEST_CHECK_EN
        if (x >= 5 || y >= 7) begin
            e.port = LOCAL;
            e.err  = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_dest(input int r, input int x, input int y);
        bus.x_dest_i[r] = 3'(x);
        bus.y_dest_i[r] = 3'(y);
    endtask

    // Monitor: every accepted result must match the head of the queue
    always @(negedge clk) begin
        if (!rst && bus.valid_o && bus.ready_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result: grant %b port %0d, none expected",
                         bus.grant_o, bus.out_port_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.grant_o !== e.grant || bus.out_port_o !== e.port ||
                    bus.err_o !== e.err) begin
                    n_bad++;
                    $display("FAIL result: got grant %b port %0d err %b, expected grant %b port %0d err %b",
                             bus.grant_o, bus.out_port_o, bus.err_o,
                             e.grant, e.port, e.err);
                end
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst          = 1'b1;
        bus.req_i    = '0;
        bus.ready_i  = 1'b0;
        bus.x_dest_i = '0;
        bus.y_dest_i = '0;
        cyc(2);
        chk("rst_valid", int'(bus.valid_o), 0);
        chk("rst_grant", int'(bus.grant_o), 0);
        chk("rst_port", int'(bus.out_port_o), int'(LOCAL));
        chk("rst_err", int'(bus.err_o), 0);
        rst = 1'b0;

        // Single request, west
        set_dest(0, 0, 3);
        bus.req_i   = 4'b0001;
        bus.ready_i = 1'b1;
        exp_q.push_back(mk(0, 0, 3));
        cyc(1);
        chk("s1_valid", int'(bus.valid_o), 1);
        cyc(1);
        bus.req_i = 4'b0000;
        cyc(2);
        chk("s1_idle", int'(bus.valid_o), 0);

        // All four held: rotation from index 0, no bubbles
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        set_dest(0, 0, 3);
        set_dest(1, 4, 3);
        set_dest(2, 2, 0);
        set_dest(3, 2, 6);
        exp_q.push_back(mk(0, 0, 3));
        exp_q.push_back(mk(1, 4, 3));
        exp_q.push_back(mk(2, 2, 0));
        exp_q.push_back(mk(3, 2, 6));
        exp_q.push_back(mk(0, 0, 3));
        bus.req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("s2_no_bubble", int'(bus.valid_o), 1);
        end
        bus.req_i = 4'b0000;
        cyc(3);

        // Stall with ready low; late request 0 waits for completion
        set_dest(2, 2, 5);
        bus.req_i   = 4'b0100;
        bus.ready_i = 1'b0;
        cyc(1);
        bus.req_i = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            chk("s3_hold_valid", int'(bus.valid_o), 1);
            chk("s3_hold_grant", int'(bus.grant_o), 4);
            chk("s3_hold_port", int'(bus.out_port_o), int'(SOUTH));
            cyc(1);
        end
        exp_q.push_back(mk(2, 2, 5));
        exp_q.push_back(mk(0, 0, 3));
        bus.ready_i = 1'b1;
        cyc(1);
        bus.req_i = 4'b0001;
        cyc(1);
        bus.req_i = 4'b0000;
        cyc(2);

        // Sweep all 35 destinations through requester 1
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 7; y++) begin
                set_dest(1, x, y);
                bus.req_i = 4'b0010;
                exp_q.push_back(mk(1, x, y));
                cyc(2);
                bus.req_i = 4'b0000;
                cyc(1);
            end
        end
        chk("s4_center_local", int'(mk(1, 2, 3).port), int'(LOCAL));

        // Reset while VALID discards the result and restarts at index 0
        set_dest(1, 4, 3);
        set_dest(2, 2, 5);
        bus.ready_i = 1'b0;
        bus.req_i   = 4'b0110;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        chk("s5_valid_after_rst", int'(bus.valid_o), 0);
        chk("s5_grant_after_rst", int'(bus.grant_o), 0);
        rst         = 1'b0;
        bus.ready_i = 1'b1;
        exp_q.push_back(mk(1, 4, 3));
        exp_q.push_back(mk(2, 2, 5));
        cyc(1);
        chk("s5_first_grant", int'(bus.grant_o), 2);
        cyc(1);
        bus.req_i = 4'b0100;
        cyc(1);
        bus.req_i = 4'b0000;
        cyc(2);

        // Destination outside the mesh
        set_dest(3, 6, 2);
        bus.req_i = 4'b1000;
        exp_q.push_back(mk(3, 6, 2));
        cyc(2);
        bus.req_i = 4'b0000;
        cyc(3);

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
